imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the word-aligned PC loaded on reset.
REQ-002 The block SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, meaning the ROM read value treated as end-of-program.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  one-cycle pulse that begins fetching from IDLE.
REQ-006 The block SHALL have port redirect_valid  input  1  branch/jump redirect request from the pipeline.
REQ-007 The block SHALL have port redirect_pc  input  32  redirect target address.
REQ-008 The block SHALL have port rom_addr  output  32  byte address to the combinational instruction ROM.
REQ-009 The block SHALL have port rom_data  input  32  ROM read data, valid in the same cycle as rom_addr.
REQ-010 The block SHALL have port if_valid  output  1  head-of-buffer instruction available to decode.
REQ-011 The block SHALL have port if_instr  output  32  head-of-buffer instruction word.
REQ-012 The block SHALL have port if_pc  output  32  address of if_instr.
REQ-013 The block SHALL have port id_ready  input  1  decode accepts head entry when if_valid and id_ready are both 1.
REQ-014 The block SHALL have port halted  output  1  high while in HALT.
REQ-015 The block SHALL have port busy  output  1  high while in FETCH or while the buffer is non-empty.

Function
REQ-016 The block SHALL implement a 3-state FSM: IDLE, FETCH, HALT.
REQ-017 The block SHALL move IDLE->FETCH on the edge where start=1, ignoring start in FETCH and HALT.
REQ-018 The block SHALL drive rom_addr = pc combinationally at all times.
REQ-019 The block SHALL hold a 2-entry FIFO of {pc, instr} pairs; if_valid = FIFO non-empty; if_instr/if_pc = head entry.
REQ-020 The block SHALL pop the head on each edge where if_valid=1 and id_ready=1.
REQ-021 In FETCH, with no redirect, rom_data != HALT_WORD, and FIFO not full or a pop occurring the same edge, the block SHALL push {pc, rom_data} and set pc <= pc + 4.
REQ-022 When FIFO is full and no pop occurs, the block SHALL neither push nor advance pc (stall).
REQ-023 In FETCH, if rom_data == HALT_WORD, the block SHALL not push, SHALL hold pc, and SHALL move to HALT; buffered entries keep draining.
REQ-024 pc + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 redirect_valid in FETCH or HALT SHALL, on that edge, flush the FIFO (including any entry popped that cycle), suppress the push, load pc <= {redirect_pc[31:2], 2'b00}, and enter FETCH.
REQ-026 redirect_valid in IDLE SHALL be ignored.
REQ-027 Redirect SHALL take priority over push, halt detection and stall in the same cycle.
REQ-028 Latency: start at edge E0 -> FETCH; first push at E1; if_valid=1 with if_pc=RESET_PC after E1.
REQ-029 Sustained throughput with id_ready=1 SHALL be one instruction per cycle.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, pc=RESET_PC, FIFO empty, if_valid=0, if_instr=0, if_pc=0, halted=0, busy=0.
REQ-031 Reset asserted mid-fetch or mid-drain SHALL discard all buffered entries; nothing is delivered after release until a new start.
REQ-032 After rst_n deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-033 Reset, ROM at 0x00=0x3C020005, start pulse, id_ready=1 -> if_valid high two edges after start with if_pc=0x0, if_instr=0x3C020005; next cycle if_pc=0x4.
REQ-034 Program 0x00..0x40 (17 words), unmapped reads return 0xFFFFFFFF, id_ready=1 -> exactly 17 instructions delivered in order, halted=1 after fetching 0x44, pc held at 0x44, busy drops after drain.
REQ-035 id_ready=0 after start -> FIFO holds pc 0x0 and 0x4, pc stays 0x8, rom_addr=0x8; release id_ready -> 0x0, 0x4, 0x8 delivered on consecutive cycles with no gap or duplicate.
REQ-036 FIFO full (0x0, 0x4), redirect_valid=1 with redirect_pc=0x3E -> FIFO flushed, pc=0x3C; next delivered if_pc=0x3C, if_instr=0x11430001.
REQ-037 In HALT, redirect to 0x14 -> state FETCH, halted=0, next delivered if_pc=0x14; redirect_valid pulsed in IDLE -> no effect, if_valid stays 0.
REQ-038 rst_n asserted while FIFO holds two entries -> if_valid, halted, busy go 0 immediately without a clock edge; pc=RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: walks a combinational instruction ROM and buffers
// fetched {pc, instr} pairs in a 2-entry FIFO ahead of decode.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        halted,
    output logic        busy
);

    localparam int unsigned W = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]   state, state_n;
    logic [W-1:0] pc, pc_n;
    logic         tail_valid, tail_valid_n;
    logic [W-1:0] tail_pc, tail_pc_n;
    logic [W-1:0] tail_instr, tail_instr_n;
    logic         head_valid_n;
    logic [W-1:0] head_pc_n, head_instr_n;
    logic         halted_n, busy_n;

    logic         pop, full, redirect, halt_hit, push;
    logic [W-1:0] redirect_aligned;

    assign rom_addr         = pc;
    assign redirect_aligned = redirect_pc & ~W'(3);

    // Next-state: redirect dominates; otherwise pop shifts tail into head, then push fills first free slot.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        head_valid_n = if_valid;
        head_pc_n    = if_pc;
        head_instr_n = if_instr;
        tail_valid_n = tail_valid;
        tail_pc_n    = tail_pc;
        tail_instr_n = tail_instr;

        pop      = if_valid & id_ready;
        full     = if_valid & tail_valid;
        redirect = redirect_valid & (state != S_IDLE);
        halt_hit = (rom_data == HALT_WORD);
        push     = (state == S_FETCH) & ~redirect & ~halt_hit & (~full | pop);

        if (redirect) begin
            head_valid_n = 1'b0;
            tail_valid_n = 1'b0;
            pc_n         = redirect_aligned;
            state_n      = S_FETCH;
        end else begin
            if (pop) begin
                head_valid_n = tail_valid;
                head_pc_n    = tail_pc;
                head_instr_n = tail_instr;
                tail_valid_n = 1'b0;
            end
            if (push) begin
                pc_n = pc + W'(4);
                if (!head_valid_n) begin
                    head_valid_n = 1'b1;
                    head_pc_n    = pc;
                    head_instr_n = rom_data;
                end else begin
                    tail_valid_n = 1'b1;
                    tail_pc_n    = pc;
                    tail_instr_n = rom_data;
                end
            end
            case (state)
                S_IDLE:  if (start) state_n = S_FETCH;
                S_FETCH: if (halt_hit) state_n = S_HALT;
                default: state_n = state;
            endcase
        end

        halted_n = (state_n == S_HALT);
        busy_n   = (state_n == S_FETCH) | head_valid_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_instr   <= '0;
            tail_valid <= 1'b0;
            tail_pc    <= '0;
            tail_instr <= '0;
            halted     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            if_valid   <= head_valid_n;
            if_pc      <= head_pc_n;
            if_instr   <= head_instr_n;
            tail_valid <= tail_valid_n;
            tail_pc    <= tail_pc_n;
            tail_instr <= tail_instr_n;
            halted     <= halted_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        halted;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [64];

    imem_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .halted(halted), .busy(busy)
    );

    always #5 clk = ~clk;

    // ROM: 64 words at 0x00, a non-halt pattern in the top 256 bytes, halt word elsewhere
    always_comb begin
        if (rom_addr[31:8] == 24'h0)            rom_data = mem[rom_addr[7:2]];
        else if (rom_addr[31:8] == 24'hFFFFFF)  rom_data = rom_addr ^ 32'h5A5A_0000;
        else                                    rom_data = HALT;
    end

    function automatic logic [31:0] rom_read(input logic [31:0] a);
        if (a < 32'h100)          return mem[a / 4];
        if (a >= 32'hFFFF_FF00)   return a ^ 32'h5A5A_0000;
        return HALT;
    endfunction

    // Reference model: mode 0=idle, 1=fetching, 2=halted
    int          m_mode;
    logic [31:0] m_pc;
    logic [63:0] m_q [$];

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 32'h0;
        m_q.delete();
    endtask

    task automatic model_step();
        logic [31:0] w;
        if (redirect_valid && m_mode != 0) begin
            m_q.delete();
            m_pc   = (redirect_pc / 4) * 4;
            m_mode = 1;
        end else begin
            if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
            if (m_mode == 1) begin
                w = rom_read(m_pc);
                if (w == HALT) m_mode = 2;
                else if (m_q.size() < 2) begin
                    m_q.push_back({m_pc, w});
                    m_pc = m_pc + 32'd4;
                end
            end else if (m_mode == 0 && start) begin
                m_mode = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({if_valid, halted, busy, if_pc, if_instr, rom_addr} !== {3'b000, 96'h0}) begin
            n_fail++;
            $display("FAIL reset_values: got v=%b h=%b b=%b pc=%h instr=%h addr=%h, want all zero",
                     if_valid, halted, busy, if_pc, if_instr, rom_addr);
        end
        rst_n = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        repeat (4) tick();
        redirect_valid = 1'b0;
        n_checks++;
        if ({if_valid, halted, busy, rom_addr} !== {3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL idle_after_reset: got v=%b h=%b b=%b addr=%h, want 0 0 0 00000000",
                     if_valid, halted, busy, rom_addr);
        end
    endtask

    task automatic test_first_fetch();
        do_reset();
        id_ready = 1'b1;
        pulse_start();
        n_checks++;
        if (if_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_e0: got v=%b b=%b, want v=0 b=1", if_valid, busy);
        end
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h3C02_0005) begin
            n_fail++;
            $display("FAIL first_instr: got v=%b pc=%h instr=%h, want 1 00000000 3c020005",
                     if_valid, if_pc, if_instr);
        end
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== mem[1]) begin
            n_fail++;
            $display("FAIL second_instr: got v=%b pc=%h instr=%h, want 1 00000004 %h",
                     if_valid, if_pc, if_instr, mem[1]);
        end
    endtask

    task automatic test_program();
        int n = 0;
        do_reset();
        id_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 60; c++) begin
            if (if_valid) begin
                n_checks++;
                if (n >= 17 || if_pc !== 32'(n * 4) || if_instr !== mem[n]) begin
                    n_fail++;
                    $display("FAIL program_order[%0d]: got pc=%h instr=%h, want pc=%h instr=%h",
                             n, if_pc, if_instr, 32'(n * 4), mem[n % 64]);
                end
                n++;
            end
            tick();
        end
        n_checks++;
        if (n !== 17 || halted !== 1'b1 || rom_addr !== 32'h44 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL program_end: got count=%0d h=%b addr=%h b=%b, want 17 1 00000044 0",
                     n, halted, rom_addr, busy);
        end
    endtask

    task automatic test_stall();
        do_reset();
        id_ready = 1'b0;
        pulse_start();
        repeat (5) tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || rom_addr !== 32'h8 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold: got v=%b pc=%h addr=%h b=%b, want 1 00000000 00000008 1",
                     if_valid, if_pc, rom_addr, busy);
        end
        id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(k * 4) || if_instr !== mem[k]) begin
                n_fail++;
                $display("FAIL stall_release[%0d]: got v=%b pc=%h instr=%h, want 1 %h %h",
                         k, if_valid, if_pc, if_instr, 32'(k * 4), mem[k]);
            end
            tick();
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        id_ready = 1'b0;
        pulse_start();
        repeat (4) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h3E;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (if_valid !== 1'b0 || rom_addr !== 32'h3C) begin
            n_fail++;
            $display("FAIL redirect_flush: got v=%b addr=%h, want 0 0000003c", if_valid, rom_addr);
        end
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h3C || if_instr !== 32'h1143_0001) begin
            n_fail++;
            $display("FAIL redirect_target: got v=%b pc=%h instr=%h, want 1 0000003c 11430001",
                     if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_halt_redirect();
        int c = 0;
        do_reset();
        id_ready = 1'b1;
        pulse_start();
        while (!halted && c < 60) begin
            tick();
            c++;
        end
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_reach: got h=%b after %0d cycles, want 1", halted, c);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h14;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (halted !== 1'b0 || busy !== 1'b1 || rom_addr !== 32'h14) begin
            n_fail++;
            $display("FAIL halt_redirect: got h=%b b=%b addr=%h, want 0 1 00000014", halted, busy, rom_addr);
        end
        tick();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h14 || if_instr !== mem[5]) begin
            n_fail++;
            $display("FAIL halt_redirect_deliver: got v=%b pc=%h, want 1 00000014", if_valid, if_pc);
        end
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_checks++;
        if (if_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_redirect: got v=%b b=%b addr=%h, want 0 0 00000000", if_valid, busy, rom_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        id_ready = 1'b1;
        pulse_start();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9;
        tick();
        redirect_valid = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] epc;
            epc = 32'hFFFF_FFF8 + 32'(k * 4);
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== epc || if_instr !== rom_read(epc)) begin
                n_fail++;
                $display("FAIL pc_wrap[%0d]: got v=%b pc=%h instr=%h, want 1 %h %h",
                         k, if_valid, if_pc, if_instr, epc, rom_read(epc));
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        id_ready = 1'b0;
        pulse_start();
        repeat (4) tick();
        n_checks++;
        if (if_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_async_reset: got v=%b b=%b, want 1 1", if_valid, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({if_valid, halted, busy, rom_addr} !== {3'b000, 32'h0}) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b h=%b b=%b addr=%h, want 0 0 0 00000000",
                     if_valid, halted, busy, rom_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        id_ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (if_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL after_async_reset: got v=%b b=%b, want 0 0", if_valid, busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(9) == 0) ? HALT : ($urandom & 32'h7FFF_FFFF);
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] head;
            head = (m_q.size() > 0) ? m_q[0] : 64'h0;
            n_checks++;
            if ({if_valid, halted, busy, rom_addr} !==
                {m_q.size() > 0, m_mode == 2, m_mode == 1 || m_q.size() > 0, m_pc}) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got v=%b h=%b b=%b addr=%h, want v=%b h=%b b=%b addr=%h",
                         i, if_valid, halted, busy, rom_addr, m_q.size() > 0, m_mode == 2,
                         m_mode == 1 || m_q.size() > 0, m_pc);
            end
            if (m_q.size() > 0) begin
                n_checks++;
                if ({if_pc, if_instr} !== head) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d]: got pc=%h instr=%h, want pc=%h instr=%h",
                             i, if_pc, if_instr, head[63:32], head[31:0]);
                end
            end
            start          = ($urandom_range(7) == 0);
            redirect_valid = ($urandom_range(15) == 0);
            redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(255)))
                                                      : 32'($urandom_range(255));
            id_ready       = ($urandom_range(3) != 0);
            model_step();
            tick();
        end
        start = 1'b0; redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = (i < 17) ? ($urandom & 32'h7FFF_FFFF) : HALT;
        mem[0]  = 32'h3C02_0005;
        mem[15] = 32'h1143_0001;
        test_reset();
        test_first_fetch();
        test_program();
        test_stall();
        test_redirect_full();
        test_halt_redirect();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
